// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage 16-bit RISC core: opcodes, instruction
// field positions and the hazard controller state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS_LSB  = 6;
  localparam int RT_LSB  = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  // Instructions that read the rs field as a source register.
  function automatic logic uses_rs(input logic [3:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW, OP_SW, OP_BEQ: uses_rs = 1'b1;
      default: uses_rs = 1'b0;
    endcase
  endfunction

  // Instructions that read the rt field as a source register.
  function automatic logic uses_rt(input logic [3:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW, OP_BEQ: uses_rt = 1'b1;
      default: uses_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline datapath.
// Handshake: there is no valid/ready pair here; every control output is a
// same-cycle combinational response to the datapath inputs and is consumed
// by the pipeline registers at the next rising clk edge.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 8);
  import cpu_pkg::*;

  logic [15:0]      id_instr;
  logic             ex_mem_read;
  logic [2:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             resume;

  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  hz_state_e        dbg_state;

  modport master (
    input  id_instr, ex_mem_read, ex_rd, ex_branch_taken, mem_busy, resume,
    output pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze, halted,
    output stall_cnt, flush_cnt, dbg_state
  );

  modport slave (
    output id_instr, ex_mem_read, ex_rd, ex_branch_taken, mem_busy, resume,
    input  pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze, halted,
    input  stall_cnt, flush_cnt, dbg_state
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increment requests until all ones, then hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline controller: load-use stalls, taken-branch squash,
// data-memory wait freeze and the HALT drain/halted/resume sequence.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.master hz
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  hz_state_e      state;
  logic [DCW-1:0] drain_cnt;
  logic [3:0]     opc;
  logic [2:0]     rs;
  logic [2:0]     rt;
  logic           load_use;
  logic           stall_inc;
  logic           flush_inc;
  logic           unused_fields;

  assign opc = hz.id_instr[OPC_LSB +: 4];
  assign rs  = hz.id_instr[RS_LSB +: 3];
  assign rt  = hz.id_instr[RT_LSB +: 3];
  // rd and the low immediate bits carry no hazard information.
  assign unused_fields = ^{hz.id_instr[RD_LSB +: 3], hz.id_instr[2:0]};

  assign load_use = hz.ex_mem_read &&
                    ((uses_rs(opc) && (rs == hz.ex_rd)) ||
                     (uses_rt(opc) && (rt == hz.ex_rd)));

  assign hz.dbg_state = state;

  // Same-cycle control decode; RUN rules are checked in priority order.
  always_comb begin
    hz.pc_we        = 1'b0;
    hz.if_id_we     = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    hz.pipe_freeze  = 1'b0;
    hz.halted       = 1'b0;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    if (reset) begin
      hz.pc_we    = 1'b1;
      hz.if_id_we = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hz.mem_busy) begin
            hz.pipe_freeze = 1'b1;
            stall_inc      = 1'b1;
          end else if (hz.ex_branch_taken) begin
            // Flush reloads IF/ID with a NOP, so it is written this edge.
            hz.pc_we        = 1'b1;
            hz.if_id_we     = 1'b1;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
            flush_inc       = 1'b1;
          end else if (load_use) begin
            hz.id_ex_bubble = 1'b1;
            stall_inc       = 1'b1;
          end else if (opc == OP_HALT) begin
            // HALT moves on into ID/EX; nothing new is fetched behind it.
            hz.if_id_flush = 1'b1;
          end else begin
            hz.pc_we    = 1'b1;
            hz.if_id_we = 1'b1;
          end
        end
        DRAIN: begin
          hz.id_ex_bubble = 1'b1;
          hz.pipe_freeze  = hz.mem_busy;
        end
        HALTED: begin
          hz.halted       = 1'b1;
          hz.id_ex_bubble = 1'b1;
        end
        default: begin
          hz.pc_we    = 1'b1;
          hz.if_id_we = 1'b1;
        end
      endcase
    end
  end

  // State and drain counter; mem_busy holds the drain while memory waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!hz.mem_busy && !hz.ex_branch_taken && !load_use && (opc == OP_HALT)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (!hz.mem_busy) begin
            if (drain_cnt == DRAIN_LAST) begin
              state     <= HALTED;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt + DCW'(1);
            end
          end
        end
        HALTED: begin
          if (hz.resume) state <= RUN;
        end
        default: begin
          state     <= RUN;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (hz.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-value queue.
module tb_pipeline_hazard_ctrl;

  localparam int W = 28;  // {mask[5:0], ctrl[5:0], stall[7:0], flush[7:0]}

  // ctrl bit order: {pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze, halted}
  localparam logic [5:0] C_NORM = 6'b110000;
  localparam logic [5:0] C_LU   = 6'b000100;
  localparam logic [5:0] C_BR   = 6'b101100;
  localparam logic [5:0] C_FRZ  = 6'b000010;
  localparam logic [5:0] C_HIN  = 6'b001000;
  localparam logic [5:0] C_DRN  = 6'b000100;
  localparam logic [5:0] C_DRB  = 6'b000110;
  localparam logic [5:0] C_HLT  = 6'b000101;
  localparam logic [5:0] C_RST  = 6'b110000;
  localparam logic [5:0] M_ALL  = 6'b111111;
  localparam logic [5:0] M_NOIF = 6'b101111;  // if_id_we left open when flushing

  logic clk;
  logic reset;
  logic chk_stb;
  int   total;
  int   bad;
  int   step_no;

  logic [W-1:0] exp_q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(8)) hz ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: inputs change on the falling edge; the check strobe fires 2ns
  // later, well before the next rising edge.
  task automatic step(input logic [15:0] instr, input logic mr, input logic [2:0] rd,
                      input logic bt, input logic busy, input logic res, input logic rst,
                      input logic [5:0] exp_c, input logic [5:0] msk,
                      input logic [7:0] exp_s, input logic [7:0] exp_f);
    @(negedge clk);
    hz.id_instr        = instr;
    hz.ex_mem_read     = mr;
    hz.ex_rd           = rd;
    hz.ex_branch_taken = bt;
    hz.mem_busy        = busy;
    hz.resume          = res;
    if (rst) begin
      #1 reset = 1'b1;
    end else begin
      reset = 1'b0;
      #1;
    end
    exp_q.push_back({msk, exp_c, exp_s, exp_f});
    #1 chk_stb = 1'b1;
    #1 chk_stb = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] e;
    logic [5:0]   act;
    forever begin
      @(posedge chk_stb);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL step%0d strobe with empty queue", step_no);
      end else begin
        e   = exp_q.pop_front();
        act = {hz.pc_we, hz.if_id_we, hz.if_id_flush, hz.id_ex_bubble, hz.pipe_freeze, hz.halted};
        total++;
        if ((act & e[27:22]) != (e[21:16] & e[27:22])) begin
          bad++;
          $display("FAIL step%0d ctrl got=%b want=%b mask=%b state=%0d",
                   step_no, act, e[21:16], e[27:22], hz.dbg_state);
        end
        total++;
        if (hz.stall_cnt != e[15:8]) begin
          bad++;
          $display("FAIL step%0d stall_cnt got=%0d want=%0d", step_no, hz.stall_cnt, e[15:8]);
        end
        total++;
        if (hz.flush_cnt != e[7:0]) begin
          bad++;
          $display("FAIL step%0d flush_cnt got=%0d want=%0d", step_no, hz.flush_cnt, e[7:0]);
        end
      end
      step_no++;
    end
  end

  // Stimulus
  initial begin
    total   = 0;
    bad     = 0;
    step_no = 0;
    chk_stb = 1'b0;
    reset   = 1'b1;
    hz.id_instr        = 16'hE000;
    hz.ex_mem_read     = 1'b0;
    hz.ex_rd           = 3'd0;
    hz.ex_branch_taken = 1'b0;
    hz.mem_busy        = 1'b0;
    hz.resume          = 1'b0;

    // reset state
    step(16'hE000, 0, 0, 0, 0, 0, 1, C_RST,  M_ALL, 8'd0, 8'd0);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL, 8'd0, 8'd0);

    // load-use on rs (ADDI rs=3), one stall then the load is in MEM
    step(16'h40C8, 1, 3, 0, 0, 0, 0, C_LU,   M_ALL, 8'd0, 8'd0);
    step(16'h40C8, 0, 3, 0, 0, 0, 0, C_NORM, M_ALL, 8'd1, 8'd0);
    // JMP reads no source
    step(16'h8000, 1, 3, 0, 0, 0, 0, C_NORM, M_ALL, 8'd1, 8'd0);
    // ADD with rt=3 stalls; ADDI ignores its rt field
    step(16'h0018, 1, 3, 0, 0, 0, 0, C_LU,   M_ALL, 8'd1, 8'd0);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL, 8'd2, 8'd0);
    step(16'h4018, 1, 3, 0, 0, 0, 0, C_NORM, M_ALL, 8'd2, 8'd0);

    // taken branch wins over a load-use
    step(16'h40C8, 1, 3, 1, 0, 0, 0, C_BR,   M_NOIF, 8'd2, 8'd0);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL,  8'd2, 8'd1);

    // 4 memory wait cycles during a load-use, then the load-use stall
    for (int i = 0; i < 4; i++)
      step(16'h40C8, 1, 3, 0, 1, 0, 0, C_FRZ, M_ALL, 8'(2 + i), 8'd1);
    step(16'h40C8, 1, 3, 0, 0, 0, 0, C_LU,   M_ALL, 8'd6, 8'd1);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL, 8'd7, 8'd1);

    // HALT with 2 busy cycles in the drain; branch in the drain is ignored
    step(16'hF000, 0, 0, 0, 0, 0, 0, C_HIN,  M_NOIF, 8'd7, 8'd1);
    step(16'hE000, 0, 0, 1, 0, 0, 0, C_DRN,  M_ALL,  8'd7, 8'd1);
    step(16'hE000, 0, 0, 0, 1, 0, 0, C_DRB,  M_ALL,  8'd7, 8'd1);
    step(16'hE000, 0, 0, 0, 1, 0, 0, C_DRB,  M_ALL,  8'd7, 8'd1);
    step(16'hE000, 0, 0, 0, 0, 1, 0, C_DRN,  M_ALL,  8'd7, 8'd1);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_DRN,  M_ALL,  8'd7, 8'd1);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_HLT,  M_ALL,  8'd7, 8'd1);
    step(16'hE000, 0, 0, 0, 0, 1, 0, C_HLT,  M_ALL,  8'd7, 8'd1);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL,  8'd7, 8'd1);

    // 300 consecutive load-use stalls saturate at 255
    for (int i = 0; i < 300; i++)
      step(16'h40C8, 1, 3, 0, 0, 0, 0, C_LU, M_ALL, (7 + i > 255) ? 8'd255 : 8'(7 + i), 8'd1);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL, 8'd255, 8'd1);

    // asynchronous reset while draining
    step(16'hF000, 0, 0, 0, 0, 0, 0, C_HIN,  M_NOIF, 8'd255, 8'd1);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_DRN,  M_ALL,  8'd255, 8'd1);
    step(16'hE000, 0, 0, 0, 0, 0, 1, C_RST,  M_ALL,  8'd0,   8'd0);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL,  8'd0,   8'd0);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL,  8'd0,   8'd0);
    step(16'h40C8, 1, 3, 0, 0, 0, 0, C_LU,   M_ALL,  8'd0,   8'd0);
    step(16'hE000, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL,  8'd1,   8'd0);

    // report
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
